// File: rtl/mat_host_pkg.sv
// rtl/mat_host_pkg.sv - shared state encoding and helpers for mat_host
// Contents: state_t (host sequencer states), MAT_A/MAT_B buffer selects,
//           cnt_width() sizing helper for down/up counters.
package mat_host_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SETUP_A,
      ST_SEND_A,
      ST_SETUP_B,
      ST_SEND_B,
      ST_START,
      ST_WAIT,
      ST_RECV,
      ST_DONE
   } state_t;

   localparam logic MAT_A = 1'b0;
   localparam logic MAT_B = 1'b1;

   // Bits needed for a counter that runs 0..n-1 (never less than 1).
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mat_host_buf.sv
// rtl/mat_host_buf.sv - SIZE x DATA_WIDTH word buffer, one write port, one registered read port
// Ports: clk, rst_n (async, clears only the read register),
//        we/waddr/wdata (write port), raddr/rdata (read data one cycle after raddr).
module mat_host_buf #(
   parameter int DATA_WIDTH = 32,
   parameter int SIZE       = 4,
   parameter int SIZE_LOG   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [SIZE_LOG-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [SIZE_LOG-1:0]   raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [SIZE];

   // Storage is deliberately not reset so operands survive a reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/mat_host.sv
// rtl/mat_host.sv - matrix accelerator host: streams A and B out, starts compute, collects result
// Ports: s00_axi_aclk/s00_axi_aresetn (clock, async active-low reset);
//        wr_en/wr_mat/wr_addr/wr_data (operand buffer writes, idle only);
//        go/busy/done/error (control/status), rd_addr/rd_data (result readback, 1-cycle latency);
//        m00_axis_* (operand stream out), s00_axis_* (result stream in);
//        sel/start (accelerator matrix select and compute start).
// Option: define MAT_HOST_TIMEOUT_EN to abort RECV after TIMEOUT idle cycles.
module mat_host
   import mat_host_pkg::*;
#(
   parameter int DIM_LOG    = 1,
   parameter int DIM        = 2**DIM_LOG,
   parameter int SIZE       = DIM*DIM,
   parameter int SIZE_LOG   = 2*DIM_LOG,
   parameter int DATA_WIDTH = 32,
   parameter int CALC_WAIT  = DIM*DIM*DIM+8,
   parameter int TIMEOUT    = 256
) (
   input  logic                  s00_axi_aclk,
   input  logic                  s00_axi_aresetn,
   input  logic                  wr_en,
   input  logic                  wr_mat,
   input  logic [SIZE_LOG-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  go,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   input  logic [SIZE_LOG-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  m00_axis_tvalid,
   output logic [DATA_WIDTH-1:0] m00_axis_tdata,
   output logic                  m00_axis_tlast,
   input  logic                  m00_axis_tready,
   input  logic                  s00_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
   input  logic                  s00_axis_tlast,
   output logic                  s00_axis_tready,
   output logic                  sel,
   output logic                  start
);

   localparam int                WCNT_W    = cnt_width(CALC_WAIT);
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(CALC_WAIT-1);
   localparam logic [SIZE_LOG-1:0] LAST_IDX = SIZE_LOG'(SIZE-1);

   state_t                state;
   logic [SIZE_LOG-1:0]   idx;
   logic [SIZE_LOG-1:0]   idx_next;
   logic [SIZE_LOG-1:0]   ridx;
   logic [WCNT_W-1:0]     wcnt;
   logic [SIZE_LOG-1:0]   send_raddr;
   logic [DATA_WIDTH-1:0] rdata_a;
   logic [DATA_WIDTH-1:0] rdata_b;
   logic                  sending;
   logic                  m_fire;
   logic                  s_beat;
   logic                  r_last;
   logic                  r_err;
   logic                  host_we;

`ifdef MAT_HOST_TIMEOUT_EN
   localparam int                TCNT_W   = cnt_width(TIMEOUT);
   localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(TIMEOUT-1);
   logic [TCNT_W-1:0]            tcnt;
`endif

   assign sending  = (state == ST_SEND_A) || (state == ST_SEND_B);
   assign m_fire   = m00_axis_tvalid && m00_axis_tready;
   assign idx_next = idx + SIZE_LOG'(1);
   assign s_beat   = s00_axis_tready && s00_axis_tvalid;
   assign r_last   = s00_axis_tlast || (ridx == LAST_IDX);
   assign r_err    = (s00_axis_tlast && (ridx != LAST_IDX)) || ((ridx == LAST_IDX) && !s00_axis_tlast);
   assign host_we  = wr_en && !busy;

   // Read address runs one word ahead on a transfer so the registered read
   // port presents word[idx] as tdata and holds it while the sink stalls.
   always_comb begin
      send_raddr = '0;
      if (sending) begin
         send_raddr = m_fire ? idx_next : idx;
      end
   end

   assign m00_axis_tdata = sel ? rdata_b : rdata_a;

   mat_host_buf #(.DATA_WIDTH(DATA_WIDTH), .SIZE(SIZE), .SIZE_LOG(SIZE_LOG)) u_buf_a (
      .clk   (s00_axi_aclk),
      .rst_n (s00_axi_aresetn),
      .we    (host_we && (wr_mat == MAT_A)),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (send_raddr),
      .rdata (rdata_a)
   );

   mat_host_buf #(.DATA_WIDTH(DATA_WIDTH), .SIZE(SIZE), .SIZE_LOG(SIZE_LOG)) u_buf_b (
      .clk   (s00_axi_aclk),
      .rst_n (s00_axi_aresetn),
      .we    (host_we && (wr_mat == MAT_B)),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (send_raddr),
      .rdata (rdata_b)
   );

   mat_host_buf #(.DATA_WIDTH(DATA_WIDTH), .SIZE(SIZE), .SIZE_LOG(SIZE_LOG)) u_buf_r (
      .clk   (s00_axi_aclk),
      .rst_n (s00_axi_aresetn),
      .we    (s_beat),
      .waddr (ridx),
      .wdata (s00_axis_tdata),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state           <= ST_IDLE;
         idx             <= '0;
         ridx            <= '0;
         wcnt            <= '0;
         m00_axis_tvalid <= 1'b0;
         m00_axis_tlast  <= 1'b0;
         s00_axis_tready <= 1'b0;
         sel             <= 1'b0;
         start           <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
`ifdef MAT_HOST_TIMEOUT_EN
         tcnt            <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (go) begin
                  state <= ST_SETUP_A;
                  busy  <= 1'b1;
                  sel   <= MAT_A;
                  error <= 1'b0;
                  idx   <= '0;
               end
            end
            // One dead cycle with tvalid low so sel settles before beat 0.
            ST_SETUP_A, ST_SETUP_B: begin
               state           <= (state == ST_SETUP_A) ? ST_SEND_A : ST_SEND_B;
               m00_axis_tvalid <= 1'b1;
               m00_axis_tlast  <= (SIZE == 1);
            end
            ST_SEND_A, ST_SEND_B: begin
               if (m_fire) begin
                  if (idx == LAST_IDX) begin
                     m00_axis_tvalid <= 1'b0;
                     m00_axis_tlast  <= 1'b0;
                     idx             <= '0;
                     if (state == ST_SEND_A) begin
                        state <= ST_SETUP_B;
                        sel   <= MAT_B;
                     end else begin
                        state <= ST_START;
                        start <= 1'b1;
                     end
                  end else begin
                     idx            <= idx_next;
                     m00_axis_tlast <= (idx_next == LAST_IDX);
                  end
               end
            end
            ST_START: begin
               start <= 1'b0;
               wcnt  <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wcnt == WAIT_LAST) begin
                  state           <= ST_RECV;
                  s00_axis_tready <= 1'b1;
                  ridx            <= '0;
`ifdef MAT_HOST_TIMEOUT_EN
                  tcnt            <= '0;
`endif
               end else begin
                  wcnt <= wcnt + WCNT_W'(1);
               end
            end
            ST_RECV: begin
               if (s_beat) begin
                  error <= error | r_err;
`ifdef MAT_HOST_TIMEOUT_EN
                  tcnt  <= '0;
`endif
                  if (r_last) begin
                     state           <= ST_DONE;
                     s00_axis_tready <= 1'b0;
                     done            <= 1'b1;
                     busy            <= 1'b0;
                  end else begin
                     ridx <= ridx + SIZE_LOG'(1);
                  end
               end
`ifdef MAT_HOST_TIMEOUT_EN
               else if (tcnt == TMO_LAST) begin
                  state           <= ST_DONE;
                  s00_axis_tready <= 1'b0;
                  done            <= 1'b1;
                  busy            <= 1'b0;
                  error           <= 1'b1;
               end else begin
                  tcnt <= tcnt + TCNT_W'(1);
               end
`endif
            end
            ST_DONE: begin
               done  <= 1'b0;
               sel   <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mat_host.sv
// tb/tb_mat_host.sv - self-checking bench for mat_host with a loop-back accelerator model
module tb_mat_host;
   localparam int DIM_LOG   = 1;
   localparam int DIM       = 2**DIM_LOG;
   localparam int SIZE      = DIM*DIM;
   localparam int SIZE_LOG  = 2*DIM_LOG;
   localparam int DW        = 32;
   localparam int CALC_WAIT = DIM*DIM*DIM+8;
   localparam int TIMEOUT   = 16;
   localparam int MAX_CYC   = 2000;

   logic                s00_axi_aclk = 1'b0;
   logic                s00_axi_aresetn = 1'b0;
   logic                wr_en = 1'b0, wr_mat = 1'b0;
   logic [SIZE_LOG-1:0] wr_addr = '0, rd_addr = '0;
   logic [DW-1:0]       wr_data = '0, rd_data, m00_axis_tdata, s00_axis_tdata = '0;
   logic                go = 1'b0, busy, done, error;
   logic                m00_axis_tvalid, m00_axis_tlast, m00_axis_tready = 1'b0;
   logic                s00_axis_tvalid = 1'b0, s00_axis_tlast = 1'b0, s00_axis_tready;
   logic                sel, start;

   always #5 s00_axi_aclk = ~s00_axi_aclk;

   mat_host #(.DIM_LOG(DIM_LOG), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
      .s00_axi_aclk(s00_axi_aclk), .s00_axi_aresetn(s00_axi_aresetn),
      .wr_en(wr_en), .wr_mat(wr_mat), .wr_addr(wr_addr), .wr_data(wr_data),
      .go(go), .busy(busy), .done(done), .error(error),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tdata(m00_axis_tdata),
      .m00_axis_tlast(m00_axis_tlast), .m00_axis_tready(m00_axis_tready),
      .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tdata(s00_axis_tdata),
      .s00_axis_tlast(s00_axis_tlast), .s00_axis_tready(s00_axis_tready),
      .sel(sel), .start(start)
   );

   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] a_mem [SIZE];
   logic [DW-1:0] b_mem [SIZE];
   logic [DW-1:0] res_mem [SIZE];
   logic [DW-1:0] cap_a [SIZE];
   logic [DW-1:0] cap_b [SIZE];
   logic [DW-1:0] prod [SIZE];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic outputs_zero(input string tag);
      chk({tag, " m_tvalid"}, m00_axis_tvalid, 0);
      chk({tag, " m_tlast"}, m00_axis_tlast, 0);
      chk({tag, " m_tdata"}, m00_axis_tdata, 0);
      chk({tag, " s_tready"}, s00_axis_tready, 0);
      chk({tag, " sel"}, sel, 0);
      chk({tag, " start"}, start, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " error"}, error, 0);
      chk({tag, " rd_data"}, rd_data, 0);
   endtask

   // Compliant accelerator: row-major C = A x B, modulo 2^DW.
   task automatic matmul();
      logic [DW-1:0] acc;
      for (int i = 0; i < DIM; i++) begin
         for (int j = 0; j < DIM; j++) begin
            acc = '0;
            for (int k = 0; k < DIM; k++) acc += cap_a[i*DIM+k] * cap_b[k*DIM+j];
            prod[i*DIM+j] = acc;
         end
      end
   endtask

   task automatic host_write(input bit mat, input int addr, input logic [DW-1:0] data);
      @(negedge s00_axi_aclk);
      wr_en = 1'b1; wr_mat = mat; wr_addr = SIZE_LOG'(addr); wr_data = data;
      @(negedge s00_axi_aclk);
      wr_en = 1'b0;
      if (mat) b_mem[addr] = data; else a_mem[addr] = data;
   endtask

   task automatic load_random();
      for (int k = 0; k < SIZE; k++) host_write(0, k, $urandom);
      for (int k = 0; k < SIZE; k++) host_write(1, k, $urandom);
   endtask

   task automatic read_all(input string tag);
      for (int k = 0; k < SIZE; k++) begin
         @(negedge s00_axi_aclk); rd_addr = SIZE_LOG'(k);
         @(negedge s00_axi_aclk);
         chk($sformatf("%s result[%0d]", tag, k), rd_data, res_mem[k]);
      end
   endtask

   // rmode: 0 sink always ready, 1 tready pattern 1,0,0,1 during SEND_A, 2 random.
   // resp_len beats offered by the responder, tlast on the last one if resp_tlast.
   // reset_at_b >= 0 asserts reset while B beat reset_at_b is pending.
   task automatic run_txn(input string tag, input int rmode, input int resp_len, input bit resp_tlast,
                          input bit noise, input int reset_at_b);
      int cyc = 0, na = 0, nb = 0, n_start = 0, start_cyc = -1, rdy_cyc = -1;
      int rx_i = 0, pat_i = 0, busy_drop = 0, exp_acc;
      bit finished = 0, started = 0, prev_stall = 0, expect_done = 0, aborted = 0, exp_err, tr, sv;
      logic [DW-1:0] prev_data = '0;
      logic prev_last = 1'b0;
      logic [0:3] pat = 4'b1001;
      exp_err = !(resp_tlast && resp_len == SIZE);
      exp_acc = (resp_len == 0) ? 0 : (resp_tlast ? resp_len : SIZE);
      @(negedge s00_axi_aclk);
      go = 1'b1;
      while (!finished && !aborted && cyc < MAX_CYC) begin
         @(negedge s00_axi_aclk);
         cyc++;
         go = 1'b0; wr_en = 1'b0;
         if (cyc == 1) begin
            chk({tag, " busy after go"}, busy, 1);
            chk({tag, " error cleared by go"}, error, 0);
         end
         if (prev_stall) begin
            chk({tag, " stall tvalid"}, m00_axis_tvalid, 1);
            chk({tag, " stall tdata"}, m00_axis_tdata, prev_data);
            chk({tag, " stall tlast"}, m00_axis_tlast, prev_last);
         end
         if (expect_done) begin
            chk({tag, " done after last beat"}, done, 1);
            chk({tag, " tready drop"}, s00_axis_tready, 0);
            expect_done = 0;
         end
         if (start) begin
            n_start++; start_cyc = cyc; started = 1;
            chk({tag, " beats before start"}, na * 16 + nb, SIZE * 16 + SIZE);
            matmul();
         end
         if (s00_axis_tready && rdy_cyc < 0) begin
            rdy_cyc = cyc;
            chk({tag, " recv entry"}, cyc - start_cyc, CALC_WAIT + 1);
         end
         if (done) begin
            finished = 1;
            chk({tag, " busy at done"}, busy, 0);
            chk({tag, " error at done"}, error, exp_err);
            chk({tag, " beats accepted"}, rx_i, exp_acc);
            if (resp_len == 0) chk({tag, " timeout latency"}, cyc - rdy_cyc, TIMEOUT);
         end else if (!busy) begin
            busy_drop++;
         end
         if (reset_at_b >= 0 && sel && m00_axis_tvalid && nb == reset_at_b) begin
            s00_axi_aresetn = 1'b0;
            m00_axis_tready = 1'b0; s00_axis_tvalid = 1'b0;
            #1 outputs_zero({tag, " async reset"});
            @(posedge s00_axi_aclk);
            #1 outputs_zero({tag, " reset edge"});
            aborted = 1;
         end else begin
            if (rmode == 1 && m00_axis_tvalid && !sel) begin
               tr = pat[pat_i % 4]; pat_i++;
            end else if (rmode == 2) begin
               tr = ($urandom % 2) == 1;
            end else begin
               tr = 1;
            end
            m00_axis_tready = tr;
            if (m00_axis_tvalid && tr) begin
               if (!sel) begin
                  chk({tag, " A beat in range"}, na < SIZE, 1);
                  if (na < SIZE) begin
                     chk($sformatf("%s A tdata[%0d]", tag, na), m00_axis_tdata, a_mem[na]);
                     chk($sformatf("%s A tlast[%0d]", tag, na), m00_axis_tlast, na == SIZE - 1);
                     cap_a[na] = m00_axis_tdata; na++;
                  end
               end else begin
                  chk({tag, " B after all A"}, na, SIZE);
                  chk({tag, " B beat in range"}, nb < SIZE, 1);
                  if (nb < SIZE) begin
                     chk($sformatf("%s B tdata[%0d]", tag, nb), m00_axis_tdata, b_mem[nb]);
                     chk($sformatf("%s B tlast[%0d]", tag, nb), m00_axis_tlast, nb == SIZE - 1);
                     cap_b[nb] = m00_axis_tdata; nb++;
                  end
               end
            end
            prev_stall = m00_axis_tvalid && !tr;
            prev_data  = m00_axis_tdata;
            prev_last  = m00_axis_tlast;
            sv = started && rx_i < resp_len && (rmode != 2 || ($urandom % 4) != 0);
            s00_axis_tvalid = sv;
            s00_axis_tdata  = (rx_i < SIZE) ? prod[rx_i] : $urandom;
            s00_axis_tlast  = resp_tlast && (rx_i == resp_len - 1);
            if (sv && s00_axis_tready) begin
               if (rx_i < SIZE) res_mem[rx_i] = s00_axis_tdata;
               if (s00_axis_tlast || rx_i == SIZE - 1) expect_done = 1;
               rx_i++;
            end
            if (noise && busy && ($urandom % 2) == 1) begin
               wr_en = 1'b1; wr_mat = $urandom_range(0, 1);
               wr_addr = SIZE_LOG'($urandom_range(0, SIZE - 1)); wr_data = $urandom;
               go = 1'b1;
            end
         end
      end
      m00_axis_tready = 1'b0; s00_axis_tvalid = 1'b0; s00_axis_tlast = 1'b0;
      go = 1'b0; wr_en = 1'b0;
      if (!aborted) begin
         chk({tag, " completed within budget"}, finished, 1);
         chk({tag, " single start pulse"}, n_start, 1);
         chk({tag, " busy held until done"}, busy_drop, 0);
         @(negedge s00_axi_aclk);
         chk({tag, " done one cycle"}, done, 0);
         chk({tag, " idle busy"}, busy, 0);
         chk({tag, " error sticky"}, error, exp_err);
      end
   endtask

   initial begin
      logic [DW-1:0] exp_basic [SIZE];
      int len;
      bit tl;
      exp_basic = '{32'd19, 32'd22, 32'd43, 32'd50};
      repeat (3) @(negedge s00_axi_aclk);
      outputs_zero("reset state");
      s00_axi_aresetn = 1'b1;

      for (int k = 0; k < SIZE; k++) host_write(0, k, DW'(k + 1));
      for (int k = 0; k < SIZE; k++) host_write(1, k, DW'(k + 5));
      run_txn("basic", 0, SIZE, 1, 0, -1);
      for (int k = 0; k < SIZE; k++) begin
         @(negedge s00_axi_aclk); rd_addr = SIZE_LOG'(k);
         @(negedge s00_axi_aclk);
         chk($sformatf("basic C[%0d]", k), rd_data, exp_basic[k]);
      end

      load_random();
      run_txn("stall", 1, SIZE, 1, 0, -1);
      read_all("stall");

      load_random();
      run_txn("short", 0, 2, 1, 0, -1);
      read_all("short");

      run_txn("no tlast", 0, SIZE, 0, 0, -1);
      read_all("no tlast");

      load_random();
      run_txn("busy noise", 2, SIZE, 1, 1, -1);
      read_all("busy noise");

      run_txn("reset mid B", 0, SIZE, 1, 0, 1);
      @(negedge s00_axi_aclk);
      s00_axi_aresetn = 1'b1;
      run_txn("replay", 0, SIZE, 1, 0, -1);
      read_all("replay");

      for (int t = 0; t < 4; t++) begin
         load_random();
         if (($urandom % 3) == 0) begin
            len = SIZE; tl = 0;
         end else begin
            len = $urandom_range(1, SIZE); tl = 1;
         end
         run_txn($sformatf("rand%0d", t), 2, len, tl, 1, -1);
         read_all($sformatf("rand%0d", t));
      end

`ifdef MAT_HOST_TIMEOUT_EN
      run_txn("timeout", 0, 0, 0, 0, -1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mat_host.md
MAT_HOST -- requirements
Module: mat_host

Interface
REQ-001 SHALL have parameters: DIM_LOG, default 1, matrix dimension log2; DIM, default 2**DIM_LOG, row/column count; SIZE, default DIM*DIM, words per matrix; SIZE_LOG, default 2*DIM_LOG, address width; DATA_WIDTH, default 32, word width; CALC_WAIT, default DIM*DIM*DIM+8, cycles held in WAIT; TIMEOUT, default 256, receive idle limit in cycles.
REQ-002 SHALL have ports (name, direction, width, meaning): s00_axi_aclk, in, 1, the single clock; s00_axi_aresetn, in, 1, asynchronous active-low reset.
REQ-003 SHALL have host write-port ports: wr_en, in, 1, operand buffer write strobe; wr_mat, in, 1, buffer select (0 = A, 1 = B); wr_addr, in, SIZE_LOG, write address; wr_data, in, DATA_WIDTH, write data.
REQ-004 SHALL have host control and readback ports: go, in, 1, start one transaction; busy, out, 1, transaction in progress; done, out, 1, one-cycle completion pulse; error, out, 1, sticky error flag; rd_addr, in, SIZE_LOG, result read address; rd_data, out, DATA_WIDTH, result read data.
REQ-005 SHALL have stream-master ports: m00_axis_tvalid, out, 1; m00_axis_tdata, out, DATA_WIDTH; m00_axis_tlast, out, 1; m00_axis_tready, in, 1.
REQ-006 SHALL have stream-slave ports: s00_axis_tvalid, in, 1; s00_axis_tdata, in, DATA_WIDTH; s00_axis_tlast, in, 1; s00_axis_tready, out, 1.
REQ-007 SHALL have accelerator control ports: sel, out, 1, accelerator matrix select; start, out, 1, accelerator compute start.

Function
REQ-008 SHALL implement the state machine IDLE -> SETUP_A -> SEND_A -> SETUP_B -> SEND_B -> START -> WAIT -> RECV -> DONE -> IDLE.
REQ-009 SHALL leave IDLE only on go=1; go is ignored in every other state.
REQ-010 SHALL drive sel=0 in SETUP_A and SEND_A, and sel=1 in SETUP_B and SEND_B; each SETUP state lasts exactly 1 cycle with tvalid=0, so sel is stable before the first beat.
REQ-011 SHALL, in SEND_x, stream buffer words at address 0..SIZE-1; a beat transfers only on tvalid&tready; tdata/tlast hold stable while tvalid=1 and tready=0.
REQ-012 SHALL assert m00_axis_tlast only on the beat at address SIZE-1, and SHALL leave SEND_x the cycle after that beat transfers.
REQ-013 SHALL pulse start for exactly 1 cycle in START, then count CALC_WAIT cycles in WAIT.
REQ-014 SHALL assert s00_axis_tready only in RECV; each beat with tvalid=1 writes the result buffer at an incrementing index from 0.
REQ-015 SHALL leave RECV on the beat with tlast=1 or on the SIZE-th beat, whichever comes first; tready drops the next cycle.
REQ-016 SHALL set error if tlast arrives before beat SIZE-1, or if beat SIZE-1 arrives without tlast; the transaction still completes.
REQ-017 SHALL hold busy=1 from SETUP_A through RECV; DONE lasts 1 cycle with done=1 and busy=0.
REQ-018 SHALL accept wr_en only while busy=0; writes while busy are dropped.
REQ-019 SHALL clear error on go.
REQ-020 SHALL return rd_data = result[rd_addr] with 1-cycle latency, in any state.

Reset
REQ-021 SHALL, on s00_axi_aresetn=0 at any time including mid-transfer, force the state to IDLE and all indices and counters to 0, with outputs m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata, s00_axis_tready, sel, start, busy, done, error and rd_data all 0.
REQ-022 SHALL NOT clear buffer contents on reset.

Configuration
REQ-023 SHALL, with MAT_HOST_TIMEOUT_EN defined, abort RECV to DONE with error=1 after TIMEOUT consecutive cycles without a beat.
REQ-024 SHALL, without MAT_HOST_TIMEOUT_EN, wait in RECV indefinitely and remove the timeout counter.

Structure
REQ-025 SHALL place the state encoding and shared localparams in package mat_host_pkg.
REQ-026 SHALL use sub-module mat_host_buf (1 write port, 1 registered read port, SIZE x DATA_WIDTH), instantiated 3 times for A, B and result.

Verification
REQ-027 SHALL cover: DIM_LOG=1, A=[1,2,3,4], B=[5,6,7,8], go, loop-back to a compliant accelerator -> result=[19,22,43,50], done pulse, error=0.
REQ-028 SHALL cover: m00_axis_tready toggling 1,0,0,1 during SEND_A -> 4 beats, data in order, tlast only on 4th, tdata stable while stalled.
REQ-029 SHALL cover: responder sends tlast on beat 2 of 4 -> done, error=1, result[0..1] written, result[2..3] unchanged.
REQ-030 SHALL cover: reset asserted mid-SEND_B -> all outputs 0 next edge; subsequent go replays full transaction correctly.
REQ-031 SHALL cover: MAT_HOST_TIMEOUT_EN defined, TIMEOUT=16, no result beats -> done 16 cycles after RECV entry, error=1.
REQ-032 SHALL cover: wr_en and go asserted while busy -> buffers unchanged, transaction not restarted.
